// File: rtl/delay_line_pkg.sv
// Shared FSM state encoding and default widths for the sample delay line.
package delay_line_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH    = 8;

endpackage

// File: rtl/ram2ports.sv
// Simple dual-port RAM: one write port, one read port with a registered read.
// Read data is valid one clk after rd_en; no backpressure.
module ram2ports #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= din;
    end
    if (rd_en) begin
      dout_q <= mem_q[rd_addr];
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/delay_line_ctrl.sv
// Delays a sample stream by D samples through an external 2-port RAM used as a ring buffer.
// Output appears exactly 1 clk after the in_valid that reads it; no backpressure, stop drops a same-cycle sample.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDRESS_WIDTH-1:0] delay,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     busy,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0]    dout
);

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] wptr_q;
  logic [ADDRESS_WIDTH-1:0] wptr_d;
  logic [ADDRESS_WIDTH-1:0] fill_cnt_q;
  logic [ADDRESS_WIDTH-1:0] dlat_q;
  logic                     out_valid_q;

  always_comb begin
    wptr_d = wptr_q + ADDR_ONE;
  end

  // Reset and stop both win over a same-cycle sample, so neither port fires.
  assign wr_en    = !rst && !stop && in_valid && (state_q != IDLE);
  assign rd_en    = !rst && !stop && in_valid && (state_q == RUN);
  assign wr_addr  = wptr_q;
  assign din      = in_data;
  assign rd_addr  = wptr_q - dlat_q;
  assign busy     = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data = dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      fill_cnt_q  <= '0;
      dlat_q      <= ADDR_ONE;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= rd_en;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= FILL;
            dlat_q     <= (delay == '0) ? ADDR_ONE : delay;
            wptr_q     <= '0;
            fill_cnt_q <= '0;
          end
        end
        FILL: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (in_valid) begin
            wptr_q <= wptr_d;
            if (fill_cnt_q == dlat_q - ADDR_ONE) begin
              state_q <= RUN;
            end else begin
              fill_cnt_q <= fill_cnt_q + ADDR_ONE;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
          end else if (in_valid) begin
            wptr_q <= wptr_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench: an 8-bit-address and a 4-bit-address delay line, each paired with ram2ports.
module tb_delay_line_ctrl;

  logic clk;
  logic rst;

  // AW=8 instance
  logic       start8, stop8, in_valid8;
  logic [7:0] delay8, in_data8;
  logic       out_valid8, busy8, wr_en8, rd_en8;
  logic [7:0] out_data8, wr_addr8, din8, rd_addr8, dout8;

  // AW=4 instance
  logic       start4, stop4, in_valid4;
  logic [3:0] delay4;
  logic [7:0] in_data4;
  logic       out_valid4, busy4, wr_en4, rd_en4;
  logic [7:0] out_data4, din4, dout4;
  logic [3:0] wr_addr4, rd_addr4;

  int n_checks = 0;
  int n_fail   = 0;

  delay_line_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .stop(stop8), .delay(delay8),
    .in_valid(in_valid8), .in_data(in_data8), .out_valid(out_valid8),
    .out_data(out_data8), .busy(busy8), .wr_en(wr_en8), .wr_addr(wr_addr8),
    .din(din8), .rd_en(rd_en8), .rd_addr(rd_addr8), .dout(dout8)
  );

  ram2ports #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) ram8 (
    .clk(clk), .wr_en(wr_en8), .wr_addr(wr_addr8), .din(din8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .dout(dout8)
  );

  delay_line_ctrl #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .delay(delay4),
    .in_valid(in_valid4), .in_data(in_data4), .out_valid(out_valid4),
    .out_data(out_data4), .busy(busy4), .wr_en(wr_en4), .wr_addr(wr_addr4),
    .din(din4), .rd_en(rd_en4), .rd_addr(rd_addr4), .dout(dout4)
  );

  ram2ports #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8)) ram4 (
    .clk(clk), .wr_en(wr_en4), .wr_addr(wr_addr4), .din(din4),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .dout(dout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle, clock it, then check the registered output it produced.
  task automatic sample8(input logic v, input logic [7:0] d, input logic ev,
                         input logic [7:0] ed, input string tag);
    in_valid8 = v;
    in_data8  = d;
    tick();
    in_valid8 = 1'b0;
    chk({tag, "_ov"}, 32'(out_valid8), 32'(ev));
    if (ev) chk({tag, "_od"}, 32'(out_data8), 32'(ed));
  endtask

  task automatic sample4(input logic v, input logic [7:0] d, input logic ev,
                         input logic [7:0] ed, input string tag);
    in_valid4 = v;
    in_data4  = d;
    tick();
    in_valid4 = 1'b0;
    chk({tag, "_ov"}, 32'(out_valid4), 32'(ev));
    if (ev) chk({tag, "_od"}, 32'(out_data4), 32'(ed));
  endtask

  task automatic start_dut8(input logic [7:0] d);
    start8 = 1'b1;
    delay8 = d;
    tick();
    start8 = 1'b0;
  endtask

  task automatic stop_dut8();
    stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start8 = 0; stop8 = 0; in_valid8 = 0; delay8 = 0; in_data8 = 0;
    start4 = 0; stop4 = 0; in_valid4 = 0; delay4 = 0; in_data4 = 0;
    tick();
    tick();
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_ov", 32'(out_valid8), 0);
    chk("rst_wr_en", 32'(wr_en8), 0);
    chk("rst_rd_en", 32'(rd_en8), 0);
    chk("rst_wr_addr", 32'(wr_addr8), 0);
    chk("rst_busy4", 32'(busy4), 0);
    rst = 1'b0;

    // delay=3, samples 10..14
    start_dut8(8'd3);
    chk("d3_busy", 32'(busy8), 1);
    sample8(1, 8'd10, 0, 8'd0,  "d3_s10");
    sample8(1, 8'd11, 0, 8'd0,  "d3_s11");
    sample8(1, 8'd12, 0, 8'd0,  "d3_s12");
    in_valid8 = 1'b1; in_data8 = 8'd13;
    #1;
    chk("d3_rd_addr", 32'(rd_addr8), 0);
    chk("d3_wr_addr", 32'(wr_addr8), 3);
    sample8(1, 8'd13, 1, 8'd10, "d3_s13");
    sample8(1, 8'd14, 1, 8'd11, "d3_s14");
    sample8(0, 8'd0,  0, 8'd0,  "d3_idle");
    stop_dut8();
    chk("d3_stop_busy", 32'(busy8), 0);

    // delay=0 behaves as delay=1
    start_dut8(8'd0);
    sample8(1, 8'd5, 0, 8'd0, "d0_s5");
    sample8(1, 8'd6, 1, 8'd5, "d0_s6");
    sample8(1, 8'd7, 1, 8'd6, "d0_s7");
    sample8(0, 8'd0, 0, 8'd0, "d0_idle");
    stop_dut8();

    // start while busy is ignored; stop beats same-cycle in_valid
    start_dut8(8'd2);
    sample8(1, 8'd20, 0, 8'd0,  "ign_s20");
    sample8(1, 8'd21, 0, 8'd0,  "ign_s21");
    sample8(1, 8'd22, 1, 8'd20, "ign_s22");
    in_valid8 = 1'b1; in_data8 = 8'd23; start8 = 1'b1; delay8 = 8'd5;
    #1;
    chk("ign_rd_addr23", 32'(rd_addr8), 1);
    tick();
    start8 = 1'b0;
    chk("ign_ov23", 32'(out_valid8), 1);
    chk("ign_od23", 32'(out_data8), 8'd21);
    in_data8 = 8'd24;
    #1;
    chk("ign_rd_addr24", 32'(rd_addr8), 2);
    tick();
    chk("ign_od24", 32'(out_data8), 8'd22);
    in_data8 = 8'd25; stop8 = 1'b1;
    #1;
    chk("stop_wr_en", 32'(wr_en8), 0);
    chk("stop_rd_en", 32'(rd_en8), 0);
    chk("stop_prev_ov", 32'(out_valid8), 1);
    chk("stop_prev_od", 32'(out_data8), 8'd22);
    tick();
    stop8 = 1'b0; in_valid8 = 1'b0;
    chk("stop_busy", 32'(busy8), 0);
    chk("stop_ov", 32'(out_valid8), 0);

    // gapped input, delay=2: one cycle on, two off
    start_dut8(8'd2);
    for (int i = 0; i < 4; i++) begin
      sample8(1, 8'(30 + i), (i >= 2), 8'(28 + i), $sformatf("gap_s%0d", i));
      sample8(0, 8'd0, 0, 8'd0, $sformatf("gap_a%0d", i));
      sample8(0, 8'd0, 0, 8'd0, $sformatf("gap_b%0d", i));
    end
    stop_dut8();

    // reset mid-RUN with in_valid high
    start_dut8(8'd1);
    sample8(1, 8'd40, 0, 8'd0, "rst_s40");
    in_valid8 = 1'b1; in_data8 = 8'd41; rst = 1'b1;
    #1;
    chk("rst_mid_wr_en", 32'(wr_en8), 0);
    tick();
    rst = 1'b0; in_valid8 = 1'b0;
    chk("rst_mid_ov", 32'(out_valid8), 0);
    chk("rst_mid_busy", 32'(busy8), 0);
    start_dut8(8'd1);
    in_valid8 = 1'b1; in_data8 = 8'd50;
    #1;
    chk("rst_restart_wr_en", 32'(wr_en8), 1);
    chk("rst_restart_wr_addr", 32'(wr_addr8), 0);
    tick();
    in_valid8 = 1'b0;
    stop_dut8();

    // AW=4, delay=15, 40 samples across the pointer wrap
    start4 = 1'b1; delay4 = 4'd15;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample4(1, 8'(i), (i >= 15), 8'(i - 15), $sformatf("wrap_s%0d", i));
    end
    sample4(0, 8'd0, 0, 8'd0, "wrap_idle");
    chk("wrap_wr_addr", 32'(wr_addr4), 8);
    chk("wrap_busy", 32'(busy4), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
